// File: rtl/aes128_stream_pkg.sv
// Shared types and constants for the aes128_stream_if word-stream front end.
package aes128_stream_pkg;

  localparam int unsigned AES_WORD_W    = 32;
  localparam int unsigned AES_BLK_WORDS = 4;
  localparam int unsigned AES_BLK_W     = AES_WORD_W * AES_BLK_WORDS;
  localparam int unsigned AES_CNT_W     = $clog2(AES_BLK_WORDS);

  typedef enum logic [1:0] {
    CMD_KEY  = 2'b00,
    CMD_ENC  = 2'b01,
    CMD_DEC  = 2'b10,
    CMD_RSVD = 2'b11
  } aes_cmd_e;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_LOADKEY,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } aes_stream_state_e;

  // Word idx of a block; word 0 is the most significant (FIPS-197 byte order).
  function automatic logic [AES_WORD_W-1:0] blk_word(input logic [AES_BLK_W-1:0] blk,
                                                     input logic [AES_CNT_W-1:0] idx);
    int unsigned sh;
    sh = AES_WORD_W * (AES_BLK_WORDS - 1 - 32'(idx));
    return AES_WORD_W'(blk >> sh);
  endfunction

  // Block with word idx replaced by w.
  function automatic logic [AES_BLK_W-1:0] blk_put(input logic [AES_BLK_W-1:0] blk,
                                                   input logic [AES_CNT_W-1:0] idx,
                                                   input logic [AES_WORD_W-1:0] w);
    int unsigned          sh;
    logic [AES_BLK_W-1:0] mask;
    logic [AES_BLK_W-1:0] ins;
    sh   = AES_WORD_W * (AES_BLK_WORDS - 1 - 32'(idx));
    mask = AES_BLK_W'({AES_WORD_W{1'b1}}) << sh;
    ins  = AES_BLK_W'(w) << sh;
    return (blk & ~mask) | ins;
  endfunction

endpackage

// File: rtl/aes128_stream_if_if.sv
// Word-stream handshake bundle between the system bus/DMA and aes128_stream_if.
interface aes128_stream_if_if;
  import aes128_stream_pkg::*;

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [AES_WORD_W-1:0] in_data_i;
  logic [1:0]            in_cmd_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [AES_WORD_W-1:0] out_data_o;
  logic                  out_last_o;
  logic                  err_o;

  modport master (
    output in_valid_i, in_data_i, in_cmd_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_last_o, err_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_cmd_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_last_o, err_o
  );
endinterface

// File: rtl/aes128_stream_if.sv
// Word-stream front end for aes128_core: packs 4 words into a block, drives the core, unpacks the result.
// Optional AES128_STREAM_KEYCHK_EN: refuse ENC/DEC (error + four zero words) until a key has been loaded.
module aes128_stream_if
  import aes128_stream_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  aes128_stream_if_if.slave    s,
  output logic                 core_load_key_o,
  output logic                 core_start_enc_o,
  output logic                 core_start_dec_o,
  output logic [AES_BLK_W-1:0] core_data_o,
  input  logic [AES_BLK_W-1:0] core_data_i,
  input  logic                 core_ready_i,
  input  logic                 core_done_i
);

  aes_stream_state_e     state_q;
  aes_cmd_e              cmd_q;
  logic [AES_BLK_W-1:0]  blk_q;
  logic [AES_CNT_W-1:0]  cnt_q;
`ifdef AES128_STREAM_KEYCHK_EN
  logic                  key_loaded_q;
`endif

  assign core_data_o = blk_q;

  // Strobes are registered, so they are armed from core_ready_i seen one cycle earlier;
  // a strobe high now means it is being issued this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_COLLECT;
      cmd_q            <= CMD_KEY;
      blk_q            <= '0;
      cnt_q            <= '0;
      s.in_ready_o     <= 1'b0;
      s.out_valid_o    <= 1'b0;
      s.out_data_o     <= '0;
      s.out_last_o     <= 1'b0;
      s.err_o          <= 1'b0;
      core_load_key_o  <= 1'b0;
      core_start_enc_o <= 1'b0;
      core_start_dec_o <= 1'b0;
`ifdef AES128_STREAM_KEYCHK_EN
      key_loaded_q     <= 1'b0;
`endif
    end else begin
      s.err_o <= 1'b0;
      case (state_q)
        ST_COLLECT: begin
          s.in_ready_o <= 1'b1;
          if (s.in_valid_i && s.in_ready_o) begin
            blk_q <= blk_put(blk_q, cnt_q, s.in_data_i);
            cnt_q <= cnt_q + AES_CNT_W'(1);
            if (cnt_q == AES_CNT_W'(0)) cmd_q <= aes_cmd_e'(s.in_cmd_i);
            if (cnt_q == AES_CNT_W'(AES_BLK_WORDS - 1)) begin
              case (cmd_q)
                CMD_KEY: begin
                  state_q         <= ST_LOADKEY;
                  s.in_ready_o    <= 1'b0;
                  core_load_key_o <= core_ready_i;
                end
                CMD_ENC, CMD_DEC: begin
`ifdef AES128_STREAM_KEYCHK_EN
                  if (!key_loaded_q) begin
                    state_q       <= ST_EMIT;
                    s.in_ready_o  <= 1'b0;
                    s.err_o       <= 1'b1;
                    blk_q         <= '0;
                    s.out_valid_o <= 1'b1;
                    s.out_data_o  <= '0;
                    s.out_last_o  <= 1'b0;
                  end else
`endif
                  begin
                    state_q          <= ST_ISSUE;
                    s.in_ready_o     <= 1'b0;
                    core_start_enc_o <= core_ready_i && (cmd_q == CMD_ENC);
                    core_start_dec_o <= core_ready_i && (cmd_q == CMD_DEC);
                  end
                end
                default: s.err_o <= 1'b1;
              endcase
            end
          end
        end

        ST_LOADKEY: begin
          if (core_load_key_o) begin
            core_load_key_o <= 1'b0;
            state_q         <= ST_COLLECT;
            s.in_ready_o    <= 1'b1;
`ifdef AES128_STREAM_KEYCHK_EN
            key_loaded_q    <= 1'b1;
`endif
          end else begin
            core_load_key_o <= core_ready_i;
          end
        end

        ST_ISSUE: begin
          if (core_start_enc_o || core_start_dec_o) begin
            core_start_enc_o <= 1'b0;
            core_start_dec_o <= 1'b0;
            state_q          <= ST_WAIT;
          end else begin
            core_start_enc_o <= core_ready_i && (cmd_q == CMD_ENC);
            core_start_dec_o <= core_ready_i && (cmd_q == CMD_DEC);
          end
        end

        ST_WAIT: begin
          if (core_done_i) begin
            blk_q         <= core_data_i;
            cnt_q         <= '0;
            state_q       <= ST_EMIT;
            s.out_valid_o <= 1'b1;
            s.out_data_o  <= blk_word(core_data_i, AES_CNT_W'(0));
            s.out_last_o  <= 1'b0;
          end
        end

        ST_EMIT: begin
          if (s.out_ready_i) begin
            cnt_q <= cnt_q + AES_CNT_W'(1);
            if (cnt_q == AES_CNT_W'(AES_BLK_WORDS - 1)) begin
              s.out_valid_o <= 1'b0;
              s.out_last_o  <= 1'b0;
              s.in_ready_o  <= 1'b1;
              state_q       <= ST_COLLECT;
            end else begin
              s.out_data_o <= blk_word(blk_q, cnt_q + AES_CNT_W'(1));
              s.out_last_o <= (cnt_q == AES_CNT_W'(AES_BLK_WORDS - 2));
            end
          end
        end

        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_stream_if.sv
// Directed self-checking bench for aes128_stream_if with a small behavioural aes128_core stand-in.
module tb_aes128_stream_if;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes128_stream_if_if bus();

  logic         core_load_key, core_start_enc, core_start_dec;
  logic [127:0] core_data_o, core_data_i;
  logic         core_ready, core_done;

  aes128_stream_if dut (
    .clk              (clk),
    .rst              (rst),
    .s                (bus),
    .core_load_key_o  (core_load_key),
    .core_start_enc_o (core_start_enc),
    .core_start_dec_o (core_start_dec),
    .core_data_o      (core_data_o),
    .core_data_i      (core_data_i),
    .core_ready_i     (core_ready),
    .core_done_i      (core_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Known-answer table (FIPS-197 C.1); anything else yields a poison value.
  function automatic logic [127:0] ref_aes(input logic enc, input logic [127:0] d, input logic [127:0] k);
    if (k == KEY && enc && d == PT) return CT;
    if (k == KEY && !enc && d == CT) return PT;
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
    logic [127:0] t;
    t = blk << (32 * i);
    return t[127:96];
  endfunction

  // Core stand-in: key register, 4-cycle latency, one-cycle done.
  logic         core_rst, rdy_block, force_done, busy_m;
  logic [127:0] key_m;
  int           lat_m;
  assign core_ready = !busy_m && !rdy_block;
  always @(posedge clk or posedge core_rst) begin
    if (core_rst) begin
      key_m <= '0; core_data_i <= '0; busy_m <= 1'b0; core_done <= 1'b0; lat_m <= 0;
    end else begin
      core_done <= force_done;
      if (core_load_key) key_m <= core_data_o;
      if (core_start_enc || core_start_dec) begin
        busy_m      <= 1'b1;
        lat_m       <= 3;
        core_data_i <= ref_aes(core_start_enc, core_data_o, key_m);
      end else if (busy_m) begin
        if (lat_m == 0) begin busy_m <= 1'b0; core_done <= 1'b1; end
        else lat_m <= lat_m - 1;
      end
    end
  end

  // Event counters sampled mid-cycle.
  int load_cnt = 0, enc_cnt = 0, dec_cnt = 0, err_cnt = 0, overlap = 0, done_cyc = -1;
  always @(negedge clk) begin
    if (core_load_key) load_cnt++;
    if (core_start_enc) enc_cnt++;
    if (core_start_dec) dec_cnt++;
    if (bus.err_o) err_cnt++;
    if ((core_start_enc && core_start_dec) || (core_load_key && (core_start_enc || core_start_dec))) overlap++;
    if (core_done) done_cyc = cyc;
  end

  logic [31:0] got_w [4];
  logic [3:0]  got_last;
  int          t_first;
  logic [15:0] stall_pat = 16'b0110_1001_1100_1011;

  // All tasks start and end at posedge+1.
  task automatic send_block(input logic [1:0] cmd, input logic [127:0] blk, input int nwords, output int t_acc);
    int guard;
    t_acc = -1;
    for (int i = 0; i < nwords; i++) begin
      bus.in_valid_i = 1'b1;
      bus.in_data_i  = word_of(blk, i);
      bus.in_cmd_i   = (i == 0) ? cmd : ~cmd;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!bus.in_ready_o && guard < 100);
      if (!bus.in_ready_o) begin
        checks++; errors++;
        $display("FAIL in_accept word %0d: in_ready_o=%b required 1", i, bus.in_ready_o);
      end
      t_acc = cyc;
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic collect_out(input bit stall);
    int          n = 0, g = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    t_first  = -1;
    got_last = '0;
    while (n < 4 && g < 300) begin
      @(posedge clk); #1;
      bus.out_ready_i = stall ? stall_pat[g % 16] : 1'b1;
      @(negedge clk);
      g++;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", bus.out_valid_o, bus.out_data_o, prev_data);
        end
      end
      prev_stall = 0;
      if (bus.out_valid_o) begin
        if (t_first < 0) t_first = cyc;
        if (bus.out_ready_i) begin
          got_w[n]    = bus.out_data_o;
          got_last[n] = bus.out_last_o;
          n++;
        end else begin
          prev_stall = 1;
          prev_data  = bus.out_data_o;
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL out_count: got %0d words required 4", n);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic check_words(input string name, input logic [127:0] exp);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_w[i] !== word_of(exp, i)) begin
        errors++;
        $display("FAIL %s word%0d: got %h required %h", name, i, got_w[i], word_of(exp, i));
      end
    end
    checks++;
    if (got_last !== 4'b1000) begin
      errors++;
      $display("FAIL %s last: got %b required 1000", name, got_last);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.err_o, core_load_key, core_start_enc, core_start_dec} !== 7'b0
        || bus.out_data_o !== 32'h0 || core_data_o !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: ctrl=%b out_data=%h core_data=%h required all zero",
               {bus.in_ready_o, bus.out_valid_o, bus.out_last_o, bus.err_o, core_load_key, core_start_enc, core_start_dec},
               bus.out_data_o, core_data_o);
    end
    @(posedge clk); #1;
  endtask

`ifdef AES128_STREAM_KEYCHK_EN
  task automatic test_keychk();
    int t, e0;
    e0 = enc_cnt;
    send_block(2'b01, PT, 4, t);
    @(negedge clk);
    checks++;
    if (cyc != t + 1 || bus.err_o !== 1'b1 || bus.out_valid_o !== 1'b1 || bus.out_data_o !== 32'h0) begin
      errors++;
      $display("FAIL keychk_t1: cyc=%0d err=%b valid=%b data=%h required cyc=%0d err=1 valid=1 data=0",
               cyc, bus.err_o, bus.out_valid_o, bus.out_data_o, t + 1);
    end
    @(posedge clk); #1;
    collect_out(0);
    check_words("keychk", 128'h0);
    checks++;
    if (enc_cnt != e0) begin
      errors++;
      $display("FAIL keychk_nostart: enc strobes %0d required %0d", enc_cnt, e0);
    end
  endtask
`endif

  task automatic test_key();
    int t, l0;
    l0 = load_cnt;
    send_block(2'b00, KEY, 4, t);
    @(negedge clk);
    checks++;
    if (cyc != t + 1 || core_load_key !== 1'b1 || bus.in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL key_t1: load=%b in_ready=%b required load=1 in_ready=0", core_load_key, bus.in_ready_o);
    end
    @(negedge clk);
    checks++;
    if (core_load_key !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL key_t2: load=%b in_ready=%b required load=0 in_ready=1", core_load_key, bus.in_ready_o);
    end
    checks++;
    if (core_data_o !== KEY || bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL key_data: core_data=%h valid=%b required %h valid=0", core_data_o, bus.out_valid_o, KEY);
    end
    @(posedge clk); #1;
    checks++;
    if (load_cnt != l0 + 1) begin
      errors++;
      $display("FAIL key_pulses: got %0d required %0d", load_cnt - l0, 1);
    end
  endtask

  task automatic test_crypt(input string name, input logic [1:0] cmd, input logic [127:0] din, input logic [127:0] exp);
    int t, e0, d0;
    e0 = enc_cnt; d0 = dec_cnt;
    send_block(cmd, din, 4, t);
    @(negedge clk);
    checks++;
    if (core_start_enc !== (cmd == 2'b01) || core_start_dec !== (cmd == 2'b10)) begin
      errors++;
      $display("FAIL %s_start: enc=%b dec=%b required enc=%b dec=%b", name, core_start_enc, core_start_dec,
               cmd == 2'b01, cmd == 2'b10);
    end
    @(posedge clk); #1;
    collect_out(0);
    check_words(name, exp);
    checks++;
    if (t_first != done_cyc + 1) begin
      errors++;
      $display("FAIL %s_latency: first valid cycle %0d required %0d", name, t_first, done_cyc + 1);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 1'b1 || cyc != done_cyc + 5) begin
      errors++;
      $display("FAIL %s_in_ready: in_ready=%b at %0d required 1 at %0d", name, bus.in_ready_o, cyc, done_cyc + 5);
    end
    @(posedge clk); #1;
    checks++;
    if (enc_cnt - e0 != int'(cmd == 2'b01) || dec_cnt - d0 != int'(cmd == 2'b10)) begin
      errors++;
      $display("FAIL %s_pulses: enc=%0d dec=%0d required enc=%0d dec=%0d", name, enc_cnt - e0, dec_cnt - d0,
               int'(cmd == 2'b01), int'(cmd == 2'b10));
    end
  endtask

  task automatic test_stall();
    int t, sc, early;
    bit found;
    early = 0; found = 0; sc = -1;
    rdy_block = 1'b1;
    send_block(2'b01, PT, 4, t);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (core_start_enc || core_start_dec) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL stall_early_start: %0d strobes while not ready required 0", early);
    end
    @(posedge clk); #1;
    rdy_block = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (core_start_enc) begin found = 1; sc = cyc; end
    end
    checks++;
    if (!found || sc <= t + 5) begin
      errors++;
      $display("FAIL stall_start: start cycle %0d required after %0d", sc, t + 5);
    end
    @(posedge clk); #1;
    collect_out(1);
    check_words("stall", CT);
  endtask

  task automatic test_rsvd();
    int t, s0, o0, e0;
    s0 = load_cnt + enc_cnt + dec_cnt;
    e0 = err_cnt;
    send_block(2'b11, PT, 4, t);
    @(negedge clk);
    checks++;
    if (bus.err_o !== 1'b1 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rsvd_t1: err=%b in_ready=%b required err=1 in_ready=1", bus.err_o, bus.in_ready_o);
    end
    o0 = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.err_o || bus.out_valid_o) o0++;
    end
    @(posedge clk); #1;
    checks++;
    if (o0 != 0 || load_cnt + enc_cnt + dec_cnt != s0 || err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL rsvd_quiet: extra=%0d strobes=%0d errs=%0d required 0 0 1", o0,
               load_cnt + enc_cnt + dec_cnt - s0, err_cnt - e0);
    end
  endtask

  task automatic test_spurious_done();
    int bad;
    bad = 0;
    force_done = 1'b1;
    @(posedge clk); #1;
    force_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL spurious_done: %0d bad cycles required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int t;
    send_block(2'b10, 128'hdeadbeef_cafef00d_01234567_89abcdef, 3, t);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready_o !== 1'b0 || core_data_o !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b core_data=%h required 0 0", bus.in_ready_o, core_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_block(2'b00, KEY, 4, t);
    repeat (3) @(posedge clk);
    #1;
    test_crypt("after_rst", 2'b01, PT, CT);
  endtask

  initial begin
    rst = 1'b1; core_rst = 1'b1; rdy_block = 1'b0; force_done = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.in_cmd_i = '0; bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0; core_rst = 1'b0;
    @(posedge clk); #1;
`ifdef AES128_STREAM_KEYCHK_EN
    test_keychk();
`endif
    test_key();
    test_crypt("enc", 2'b01, PT, CT);
    test_crypt("dec", 2'b10, CT, PT);
    test_stall();
    test_rsvd();
    test_spurious_done();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL strobe_overlap: %0d cycles required 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes128_stream_if.md
# aes128_stream_if

Word-stream front end for `aes128_core`:
- Collects four 32-bit input words into a 128-bit block, tagged with a command.
- Drives the core's key-load and encrypt/decrypt controls and 128-bit data input.
- Captures the core result on its single-cycle done strobe and returns it as four 32-bit output words.

It sits directly between the system bus/DMA and `aes128_core`.

## Interface
Parameters:
- none (block width fixed at 128 bits, word width at 32 bits)

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `in_valid_i` in 1: input word valid
- `in_ready_o` out 1: input word accepted when `in_valid_i && in_ready_o`
- `in_data_i` in 32: input word
- `in_cmd_i` in 2: command, sampled with word 0 only. Encoding: 00 KEY, 01 ENC, 10 DEC, 11 reserved
- `out_valid_o` out 1: output word valid
- `out_ready_i` in 1: output word consumed when `out_valid_o && out_ready_i`
- `out_data_o` out 32: output word
- `out_last_o` out 1: marks word 3 of the output block
- `err_o` out 1: one-cycle error pulse
- `core_load_key_o` out 1: to core `load_key_i`
- `core_start_enc_o` out 1: to core `start_enc_i`
- `core_start_dec_o` out 1: to core `start_dec_i`
- `core_data_o` out 128: to core `data_i`
- `core_data_i` in 128: from core `data_o`
- `core_ready_i` in 1: from core `ready_o`
- `core_done_i` in 1: from core `done_o`

## Operation
- One 128-bit buffer `buf` and a 2-bit word counter `cnt`.
  - Word k maps to `buf[127-32k -: 32]`, so word 0 is the MSW (FIPS-197 byte order).
  - `core_data_o` = `buf` at all times.
- States: COLLECT, LOADKEY, ISSUE, WAIT, EMIT.
- COLLECT
  - `in_ready_o` = 1.
  - Each accepted word is written into `buf` and increments `cnt`.
  - `in_cmd_i` is latched on word 0; its value on words 1–3 is ignored.
  - On acceptance of word 3 (`cnt` wraps to 0):
    - cmd KEY → LOADKEY.
    - cmd ENC or DEC → ISSUE.
    - cmd reserved → `err_o` pulses next cycle, block is dropped, state stays COLLECT.
- LOADKEY
  - Waits for `core_ready_i`.
  - Asserts `core_load_key_o` for exactly one cycle, then → COLLECT.
  - Produces no output words.
- ISSUE
  - Waits for `core_ready_i`.
  - Asserts `core_start_enc_o` or `core_start_dec_o` (per latched cmd) for exactly one cycle, then → WAIT.
  - Both start strobes are never high together.
  - Load and start strobes are never high together.
- WAIT
  - On `core_done_i`, loads `core_data_i` into `buf` in the same cycle, then → EMIT.
  - `buf` stays stable from the start strobe until done.
- EMIT
  - `out_valid_o` = 1, `out_data_o` = word `cnt` of `buf`, `out_last_o` = (`cnt` == 3).
  - `cnt` advances on each handshake.
  - After word 3 is consumed → COLLECT.
  - `out_data_o` must hold stable while `out_valid_o && !out_ready_i`.
- `in_ready_o` = 0 in every state except COLLECT. No overlap of input and output blocks.
- `core_done_i` outside WAIT is ignored.

## Timing
- Reset value of every output is 0; the buffer, counter and latched cmd are also cleared to 0; state resets to COLLECT.
- Reset mid-block discards the partial block.
- KEY path:
  - Word 3 accepted in cycle T → `core_load_key_o` high in T+1 if `core_ready_i` is high.
  - `in_ready_o` high again in T+2.
- ENC/DEC path:
  - Word 3 accepted in cycle T → start strobe in T+1 at the earliest.
  - Core done in cycle D → `out_valid_o` high in D+1, word 0 presented.
- Output throughput is 1 word per cycle with `out_ready_i` held high. Last output handshake in D+4 → `in_ready_o` high in D+5.
- `err_o` is high for exactly one cycle, the cycle after word 3 is accepted.

## Configuration
- `AES128_STREAM_KEYCHK_EN`
  - Defined: a `key_loaded` flag is set by the first completed LOADKEY and cleared only by reset. An ENC/DEC block arriving with `key_loaded` = 0:
    - does not start the core;
    - pulses `err_o` in T+1;
    - emits four 0x00000000 words, the first with `out_valid_o` high in T+1.
  - Undefined: no flag; ENC/DEC always starts the core (which then uses its reset key of zero).

## Structure
- Package `aes128_stream_pkg` holds:
  - cmd enum `aes_cmd_e` (KEY, ENC, DEC, RSVD);
  - state enum `aes_stream_state_e`;
  - constants `AES_WORD_W` = 32 and `AES_BLK_WORDS` = 4.
- No sub-module: one FSM, one counter and one shared 128-bit buffer in a single module.

## Test plan
- KEY block 00010203 04050607 08090a0b 0c0d0e0f → `core_load_key_o` single pulse; `core_data_o` = 000102030405060708090a0b0c0d0e0f; no `out_valid_o`.
- Then ENC block 00112233 44556677 8899aabb ccddeeff → one `core_start_enc_o` pulse; output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a with `out_last_o` on the fourth.
- DEC block 69c4e0d8 … 70b4c55a → one `core_start_dec_o` pulse; outputs 00112233 … ccddeeff.
- Random `out_ready_i` stalls during EMIT, plus `core_ready_i` held low 5 cycles in ISSUE → `out_data_o` stable under stall, start delayed until ready, words in order.
- Reserved cmd 11 → `err_o` one-cycle pulse, no core strobe, `in_ready_o` high next cycle. With KEYCHK_EN, ENC before any KEY → `err_o` pulse plus four zero output words.
- `rst` asserted after word 2 of a block, then a full ENC block → partial block discarded, correct ciphertext for the new block.
